// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer: serialises sync + data bytes onto NRZI-encoded D+/D- with bit stuffing and EOP.
// Line symbols are registered on the same edge that enters the bit they carry.
module usb_tx_sequencer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       byte_valid,
    input  logic       last_byte,
    output logic       byte_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt;
    logic [2:0] r_idx, w_idx_nxt, r_ones, w_ones_nxt, w_ones_inc;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_last, w_last_nxt, r_end, w_end_nxt, r_level, w_level_nxt;
    logic       r_dp, r_dm, r_done;
    logic       w_strobe, w_bit, w_nbit, w_tick, w_sym, w_base;

    assign w_strobe   = (r_cnt == 8'(CLKS_PER_BIT - 1));
    assign w_bit      = (r_state == SYNC) ? (r_idx == 3'd7) : r_shift[r_idx];
    assign w_ones_inc = w_bit ? r_ones + 3'd1 : 3'd0;
    assign byte_ready = w_strobe && (r_idx == 3'd7) && (r_state == SYNC || (r_state == DATA && !r_last));
    assign underrun   = byte_ready && !byte_valid;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign d_plus     = r_dp;
    assign d_minus    = r_dm;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ones_nxt  = r_ones;
        w_shift_nxt = r_shift;
        w_last_nxt  = r_last;
        w_end_nxt   = r_end;
        if (r_state == IDLE) begin
            if (start) begin
                w_state_nxt = SYNC;
                w_idx_nxt   = 3'd0;
                w_ones_nxt  = 3'd0;
                w_end_nxt   = 1'b0;
                w_last_nxt  = 1'b0;
            end
        end else if (w_strobe) begin
            if (r_state == SYNC || r_state == DATA) begin
                w_idx_nxt  = r_idx + 3'd1;
                w_ones_nxt = (w_ones_inc == 3'd6) ? 3'd0 : w_ones_inc;
                if (byte_ready && byte_valid) begin
                    w_shift_nxt = tx_byte;
                    w_last_nxt  = last_byte;
                end
                w_end_nxt   = underrun || (r_state == DATA && r_idx == 3'd7 && r_last);
                w_state_nxt = (w_ones_inc == 3'd6) ? STUFF : w_end_nxt ? EOP_SE0 : (r_idx == 3'd7) ? DATA : r_state;
            end else if (r_state == STUFF) begin
                w_state_nxt = r_end ? EOP_SE0 : DATA;
            end else if (r_state == EOP_SE0) begin
                w_idx_nxt   = r_idx[0] ? 3'd0 : r_idx + 3'd1;
                w_state_nxt = r_idx[0] ? EOP_J : EOP_SE0;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    // NRZI: the level only moves when a new bit begins; a packet always starts from J
    assign w_tick      = (r_state == IDLE) ? start : w_strobe;
    assign w_sym       = (w_state_nxt == SYNC) || (w_state_nxt == DATA) || (w_state_nxt == STUFF);
    assign w_nbit      = (w_state_nxt == SYNC) ? (w_idx_nxt == 3'd7) : (w_state_nxt == DATA) ? w_shift_nxt[w_idx_nxt] : 1'b0;
    assign w_base      = (r_state == IDLE) ? 1'b1 : r_level;
    assign w_level_nxt = (w_tick && w_sym) ? (w_nbit ? w_base : ~w_base) : r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= 3'd0;
            r_ones  <= 3'd0;
            r_shift <= 8'd0;
            r_last  <= 1'b0;
            r_end   <= 1'b0;
            r_level <= 1'b1;
            r_dp    <= 1'b1;
            r_dm    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == IDLE || w_strobe) ? 8'd0 : r_cnt + 8'd1;
            r_idx   <= w_idx_nxt;
            r_ones  <= w_ones_nxt;
            r_shift <= w_shift_nxt;
            r_last  <= w_last_nxt;
            r_end   <= w_end_nxt;
            r_level <= w_level_nxt;
            r_dp    <= w_sym ? w_level_nxt : (w_state_nxt != EOP_SE0);
            r_dm    <= w_sym ? ~w_level_nxt : 1'b0;
            r_done  <= (r_state == EOP_J) && w_strobe;
        end
    end
endmodule
